// File: rtl/demux_pkg.sv
// Shared constants, types and helpers for the 1:4 stream demultiplexer.
package demux_pkg;

    localparam int NUM_CH = 4;
    localparam int SEL_W  = 2;

    typedef logic [SEL_W-1:0] ch_idx_t;

    // Bit offset of channel k inside a flattened bus of w-bit slices.
    function automatic int slice_off(input int k, input int w);
        return k * w;
    endfunction

endpackage

// File: rtl/demux_slot.sv
// One-entry output slot: holding register with valid/ready, a load port
// driven by the distributor and a count of beats delivered downstream.
module demux_slot #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             ready,
    output logic             valid,
    output logic [WIDTH-1:0] data,
    output logic [CNT_W-1:0] cnt
);

    logic             full_reg, full_next;
    logic [WIDTH-1:0] data_reg, data_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             drain;

    assign drain = full_reg && ready;

    // Next-state: a load wins over a drain so a simultaneous drain+load
    // keeps the slot full with the new beat; empty slots keep stale data.
    always_comb begin
        full_next = full_reg;
        data_next = data_reg;
        cnt_next  = cnt_reg;
        if (load) begin
            full_next = 1'b1;
            data_next = load_data;
        end else if (drain) begin
            full_next = 1'b0;
        end
        if (drain) begin
            cnt_next = cnt_reg + 1'b1;
        end
    end

    // State register with synchronous reset discarding any held beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            full_reg <= 1'b0;
            data_reg <= '0;
            cnt_reg  <= '0;
        end else begin
            full_reg <= full_next;
            data_reg <= data_next;
            cnt_reg  <= cnt_next;
        end
    end

    assign valid = full_reg;
    assign data  = data_reg;
    assign cnt   = cnt_reg;

endmodule

// File: rtl/demux1to4_stream.sv
// Registered 1:4 stream demultiplexer. Picks a target channel from either
// in_sel or a round-robin pointer and loads the beat into that channel's
// one-entry slot; each slot drains through its own valid/ready handshake.
module demux1to4_stream
    import demux_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [WIDTH-1:0]        in_data,
    input  logic [1:0]              in_sel,
    input  logic                    rr_mode,
    output logic [3:0]              out_valid,
    input  logic [3:0]              out_ready,
    output logic [4*WIDTH-1:0]      out_data,
    output logic [4*CNT_W-1:0]      beat_cnt
);

    ch_idx_t             ptr_reg, ptr_next;
    ch_idx_t             target;
    logic                accept;
    logic [NUM_CH-1:0]   full;
    logic [NUM_CH-1:0]   load;

    // Target channel and input readiness; readiness passes the target's
    // out_ready through so a draining slot can be refilled in the same cycle.
    always_comb begin
        target   = rr_mode ? ptr_reg : ch_idx_t'(in_sel);
        in_ready = !full[target] || out_ready[target];
        accept   = in_valid && in_ready;
    end

    // Round-robin pointer advances only on accepted beats in round-robin
    // mode, and otherwise holds so routing resumes where it left off.
    always_comb begin
        ptr_next = ptr_reg;
        if (accept && rr_mode) begin
            ptr_next = ptr_reg + 1'b1;
        end
    end

    // Pointer register.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_reg <= '0;
        end else begin
            ptr_reg <= ptr_next;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_slot
            assign load[gi] = accept && (target == ch_idx_t'(gi));

            demux_slot #(
                .WIDTH (WIDTH),
                .CNT_W (CNT_W)
            ) u_slot (
                .clk       (clk),
                .rst       (rst),
                .load      (load[gi]),
                .load_data (in_data),
                .ready     (out_ready[gi]),
                .valid     (full[gi]),
                .data      (out_data[slice_off(gi, WIDTH) +: WIDTH]),
                .cnt       (beat_cnt[slice_off(gi, CNT_W) +: CNT_W])
            );
        end
    endgenerate

    assign out_valid = full;

endmodule

// File: doc/demux1to4_stream.md
Name: demux1to4_stream

Overview:
Registered 1:4 demultiplexer. It is the distribution counterpart of the 4:1 selector used on the datapath. It accepts one WIDTH-bit beat per cycle on a valid/ready input and routes it to one of four output channels. Each output channel has a one-entry holding register and its own valid/ready handshake. The target channel comes from either an explicit select or an internal round-robin pointer. Per-channel delivered-beat counters support debug.

Parameters:
WIDTH, 8, data width of the input beat and of each output channel
CNT_W, 8, width of each per-channel delivered-beat counter

Ports:
clk  in  1  single clock; all state updates on the rising edge
rst  in  1  synchronous, active-high reset
in_valid  in  1  input beat present
in_ready  out  1  block can accept the beat this cycle
in_data  in  WIDTH  input beat
in_sel  in  2  explicit target channel, used when rr_mode=0
rr_mode  in  1  1 = round-robin target, 0 = in_sel target
out_valid  out  4  bit k: channel k holds a beat
out_ready  in  4  bit k: channel k consumer accepts
out_data  out  4*WIDTH  channel k data on bits [k*WIDTH +: WIDTH]
beat_cnt  out  4*CNT_W  channel k delivered-beat count on bits [k*CNT_W +: CNT_W]

Behaviour:
- Target channel: t = rr_mode ? ptr : in_sel. Evaluated combinationally from the current-cycle rr_mode, ptr and in_sel.
- Slot k state: full[k] and data_q[k]. out_valid[k] = full[k]. out_data slice k = data_q[k].
- Readiness: in_ready = !full[t] || out_ready[t]. This is a pass-through of the target's ready, which allows back-to-back beats into one channel at 1 beat/cycle.
- Input accept: accept = in_valid && in_ready.
- On accept:
  - data_q[t] <= in_data and full[t] <= 1.
  - Latency is 1 cycle: the beat appears on out_valid/out_data of channel t in the cycle after acceptance.
- Drain: slot k drains when full[k] && out_ready[k].
  - If slot k drains and is not loaded in the same cycle, full[k] <= 0.
  - If slot k drains and is loaded in the same cycle, full[k] stays 1 with the new data; no bubble, no loss.
- Empty slots: data_q[k] holds its last value when empty. It is not cleared except by reset.
- Non-target channels drain independently in the same cycle as an accept to t.
- Round-robin pointer ptr (2 bits):
  - Increments only on accept while rr_mode=1; wraps 3->0.
  - Holds its value while rr_mode=0.
  - When rr_mode returns to 1, routing resumes from the held ptr value.
- Upstream rule: in_data and in_sel must be held stable while in_valid=1 and in_ready=0. in_valid=0 never changes state.
- beat_cnt[k]: increments by 1 on each drain of slot k, modulo 2^CNT_W (255->0 at CNT_W=8).
- Reset (rst=1 at a clock edge): full=0, data_q=0, ptr=0, beat_cnt=0.
  - Outputs after reset: out_valid=4'b0000, out_data=0, beat_cnt=0.
  - in_ready = 1 after reset, since every slot is empty.
  - Reset overrides any accept or drain in the same cycle.
  - Reset mid-stream discards all held beats.
- No X propagation: in_sel is ignored when rr_mode=1; rr_mode and in_sel are don't-care when in_valid=0.

Decomposition:
- Package demux_pkg holds: NUM_CH=4, SEL_W=2, the channel-index type, and a helper function for the slice offset (k*WIDTH).
- Sub-module demux_slot: one-entry register with valid/ready, a load port and a drain counter. It is instantiated 4 times by a generate loop.
- The top level keeps target selection, in_ready, ptr and port flattening.

Test Plan:
1. Reset then idle. Hold rst=1 two cycles, then release -> out_valid=0000, out_data=0, beat_cnt=0, in_ready=1.
2. Explicit select, all consumers ready (out_ready=1111). rr_mode=0; send 8'hA1 with sel=0, 8'hB2 with sel=1, 8'hC3 with sel=2, 8'hD4 with sel=3 on consecutive cycles -> each value appears on its channel one cycle later; beat_cnt = 1,1,1,1.
3. Backpressure. out_ready[2]=0; send 8'h11 then 8'h22 to sel=2:
   - in_ready drops in the cycle after 8'h11 is loaded.
   - 8'h22 is held until out_ready[2]=1.
   - Channel 2 then shows 8'h11, then 8'h22 back-to-back.
   - Meanwhile a beat sent to sel=0 passes unaffected.
4. Round-robin wrap. rr_mode=1, out_ready=1111; send 6 beats 8'h01..8'h06 -> channels receive them in order 0,1,2,3,0,1; ptr=2 afterwards. Switch rr_mode=0 for 2 beats, then back to 1 -> the next round-robin beat goes to channel 2.
5. Simultaneous drain and load. Channel 1 full with 8'h55, out_ready[1]=1, and 8'h66 sent to channel 1 in the same cycle -> out_valid[1] stays 1 and the next cycle shows 8'h66; beat_cnt[1] increments once.
6. Reset mid-operation and counter wrap:
   - Fill all slots with out_ready=0000, then assert rst for one cycle -> all out_valid=0, ptr=0.
   - Separately, drain 256 beats on channel 3 -> beat_cnt[3] wraps to 0.
